// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack, decoder valid/ready.
// FETCH_SKID_EN selects a 2-entry output FIFO instead of one register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
);

  logic [31:0] pc;
  logic [31:0] drain_addr;
  logic [31:0] redir;

  assign redir = redirect_pc & ~32'h3;

`ifdef FETCH_SKID_EN

  logic [31:0] fifo_ins [2];
  logic [31:0] fifo_pc  [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  cnt;
  logic        drain;
  logic        push;
  logic        pop;

  assign imem_req    = !rst && (drain || cnt != 2'd2);
  assign imem_addr   = drain ? drain_addr : pc;
  assign instr_valid = cnt != 2'd0;
  assign instruction = instr_valid ? fifo_ins[rd_ptr] : NOP_INSTR;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr] : 32'h0;
  assign push = imem_req && imem_ack && !drain && !redirect;
  assign pop  = instr_valid && instr_ready && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      drain_addr <= 32'h0;
      drain      <= 1'b0;
      cnt        <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
    end else if (redirect) begin
      pc     <= redir;
      cnt    <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      // an unacked request must still complete before refetching
      if (drain) begin
        if (imem_ack) drain <= 1'b0;
      end else if (imem_req && !imem_ack) begin
        drain      <= 1'b1;
        drain_addr <= pc;
      end
    end else if (drain) begin
      if (imem_ack) drain <= 1'b0;
    end else begin
      if (push) begin
        fifo_ins[wr_ptr] <= imem_rdata;
        fifo_pc[wr_ptr]  <= pc;
        wr_ptr           <= ~wr_ptr;
        pc               <= pc + 32'd4;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

`else

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
  state_t state;

  assign imem_req  = !rst && (state != HOLD);
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      drain_addr  <= 32'h0;
      instr_valid <= 1'b0;
      instruction <= NOP_INSTR;
      instr_pc    <= 32'h0;
    end else begin
      unique case (state)
        FETCH: begin
          if (redirect) begin
            pc <= redir;
            if (!imem_ack) begin
              state      <= DRAIN;
              drain_addr <= pc;
            end
          end else if (imem_ack) begin
            instruction <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 32'd4;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (redirect || instr_ready) begin
            if (redirect) pc <= redir;
            state       <= FETCH;
            instr_valid <= 1'b0;
            instruction <= NOP_INSTR;
            instr_pc    <= 32'h0;
          end
        end
        DRAIN: begin
          if (redirect) pc <= redir;
          if (imem_ack) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed steps then random traffic,
// checked every cycle against a queue-based reference model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
`ifdef FETCH_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  // Reference: fetched-but-undelivered instructions, next fetch pc,
  // and a pending wrong-path request that must still be acked.
  ent_t        q[$];
  logic [31:0] m_pc = RESET_PC;
  logic        m_drain = 1'b0;
  logic [31:0] m_daddr = 32'h0;
  logic [31:0] salt = 32'h0;

  int total = 0;
  int bad = 0;

  function automatic logic exp_req();
    return !rst && (m_drain || q.size() < CAP);
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_drain ? m_daddr : m_pc;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check();
    cmp("imem_req", {31'h0, imem_req}, {31'h0, exp_req()});
    if (exp_req()) cmp("imem_addr", imem_addr, exp_addr());
    cmp("instr_valid", {31'h0, instr_valid}, {31'h0, q.size() > 0});
    cmp("instruction", instruction, q.size() > 0 ? q[0].ins : NOP_INSTR);
    cmp("instr_pc", instr_pc, q.size() > 0 ? q[0].pc : 32'h0);
  endtask

  task automatic model_update();
    logic ack;
    ack = exp_req() && imem_ack;
    if (rst) begin
      q.delete();
      m_pc = RESET_PC;
      m_drain = 1'b0;
    end else if (redirect) begin
      if (m_drain) begin
        if (ack) m_drain = 1'b0;
      end else if (exp_req() && !ack) begin
        m_drain = 1'b1;
        m_daddr = m_pc;
      end
      q.delete();
      m_pc = redirect_pc & ~32'h3;
    end else if (m_drain) begin
      if (ack) m_drain = 1'b0;
    end else begin
      if (q.size() > 0 && instr_ready) q.delete(0);
      if (ack) begin
        q.push_back('{m_pc, imem_rdata});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic step(input logic r, input logic rd,
                      input logic [31:0] rpc, input logic rdy,
                      input logic ak, input logic chk);
    @(negedge clk);
    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    instr_ready = rdy;
    imem_ack    = ak;
    imem_rdata  = exp_addr() ^ 32'hA5A5_0000 ^ salt;
    #1;
    if (chk) check();
    @(posedge clk);
    model_update();
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 1);
    // zero-wait memory, decoder always ready
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1, 1);
    // 3-cycle memory latency
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1, 1);
    // decoder stalls for 5 cycles with data held
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0, 1);
    // redirect in middle of a wait: old request drains
    step(0, 0, 0, 1, 0, 1);
    step(0, 1, 32'h0000_0102, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 1);
    // redirect together with ack, then together with ready
    step(0, 1, 32'h0000_0040, 1, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 1, 32'h0000_0040, 1, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 1);
    // second redirect during drain overrides the first
    step(0, 0, 0, 1, 0, 1);
    step(0, 1, 32'h0000_0200, 1, 0, 1);
    step(0, 1, 32'h0000_0300, 1, 0, 1);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    // reset during a wait with ack arriving under reset
    step(0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 1, 1);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1, 1);
    // pc wraps past the top of the address space
    step(0, 1, 32'hFFFF_FFF9, 1, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1, 1);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      salt = $urandom;
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 14) == 0,
           $urandom_range(0, 7) == 0 ? 32'hFFFF_FFF0 | $urandom_range(0, 15)
                                     : $urandom,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 1) == 1,
           1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
